// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : display codes and widths shared by the scanner and converter
// Rev 1.0
// ============================================================================
`default_nettype none

package display_pkg;

  localparam int ANCHO_COD    = 5;
  localparam int ANCHO_NIBBLE = 4;

  localparam logic [ANCHO_COD-1:0] COD_BLANCO = 5'b10000;
  localparam logic [ANCHO_COD-1:0] COD_GUION  = 5'b10001;

  function automatic logic [ANCHO_COD-1:0] cod_dato(input logic [ANCHO_NIBBLE-1:0] nib);
    return {1'b0, nib};
  endfunction

endpackage

`default_nettype wire

// File: rtl/divisor_tick.sv
// ============================================================================
// divisor_tick : free-running prescaler 0..DIV-1 with a wrap strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module divisor_tick #(
  parameter int DIV = 50000,
  parameter int PW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [PW-1:0] presc,
  output logic          tick
);

  localparam logic [PW-1:0] c_presc_max = PW'(DIV - 1);

  assign tick = (presc == c_presc_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/barrido_display.sv
// ============================================================================
// barrido_display : N-digit 7-segment scanner with frame-aligned double buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module barrido_display
  import display_pkg::*;
#(
  parameter int N_DIGITOS    = 4,
  parameter int DIV_REFRESCO = 50000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ANCHO_NIBBLE*N_DIGITOS-1:0] datos,
  input  logic                              cargar,
  input  logic                              blank_ceros,
  input  logic                              error,
  output logic [ANCHO_COD-1:0]              hex,
  output logic [N_DIGITOS-1:0]              anodos,
  output logic                              pendiente
);

  localparam int IW = $clog2(N_DIGITOS);
  localparam int PW = $clog2(DIV_REFRESCO);
  localparam int DW = ANCHO_NIBBLE * N_DIGITOS;

  localparam logic [IW-1:0]        c_idx_max   = IW'(N_DIGITOS - 1);
  localparam logic [PW-1:0]        c_presc_max = PW'(DIV_REFRESCO - 1);
  localparam logic [N_DIGITOS-1:0] c_uno       = N_DIGITOS'(1);

  logic [PW-1:0]           w_presc;
  logic                    w_tick;
  logic                    w_frontera;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           w_idx_sig;
  logic [DW-1:0]           r_entrada;
  logic [DW-1:0]           r_visible;
  logic [DW-1:0]           w_visible_sig;
  logic                    r_pendiente;
  logic [ANCHO_NIBBLE-1:0] w_nib;
  logic                    w_ceros;
  logic [ANCHO_COD-1:0]    w_cod;
  logic [N_DIGITOS-1:0]    w_anod;

  divisor_tick #(
    .DIV (DIV_REFRESCO),
    .PW  (PW)
  ) u_divisor (
    .clk   (clk),
    .rst_n (rst_n),
    .presc (w_presc),
    .tick  (w_tick)
  );

  assign w_frontera = w_tick && (r_idx == c_idx_max);
  assign pendiente  = r_pendiente;

  always_comb begin
    w_idx_sig = r_idx;
    if (w_tick) begin
      w_idx_sig = (r_idx == c_idx_max) ? '0 : r_idx + IW'(1);
    end
  end

  // Outputs are built from the buffer state of the next cycle so digit 0 of a new frame shows new data.
  always_comb begin
    w_visible_sig = r_visible;
    if (w_frontera) begin
      if (cargar) begin
        w_visible_sig = datos;
      end else if (r_pendiente) begin
        w_visible_sig = r_entrada;
      end
    end
  end

  always_comb begin
    w_nib   = '0;
    w_ceros = 1'b1;
    for (int j = 0; j < N_DIGITOS; j++) begin
      if (IW'(j) == w_idx_sig) begin
        w_nib = w_visible_sig[j*ANCHO_NIBBLE +: ANCHO_NIBBLE];
      end
      if (IW'(j) >= w_idx_sig && w_visible_sig[j*ANCHO_NIBBLE +: ANCHO_NIBBLE] != '0) begin
        w_ceros = 1'b0;
      end
    end

    if (error) begin
      w_cod = COD_GUION;
    end else if (blank_ceros && (w_idx_sig != '0) && w_ceros) begin
      w_cod = COD_BLANCO;
    end else begin
      w_cod = cod_dato(w_nib);
    end

    // Prescaler about to wrap: next cycle opens a slot with all anodes off.
    if (w_presc == c_presc_max) begin
      w_anod = '1;
    end else begin
      w_anod = ~(c_uno << w_idx_sig);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      hex    <= COD_BLANCO;
      anodos <= '1;
    end else begin
      r_idx  <= w_idx_sig;
      hex    <= w_cod;
      anodos <= w_anod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entrada   <= '0;
      r_visible   <= '0;
      r_pendiente <= 1'b0;
    end else if (w_frontera) begin
      if (cargar) begin
        r_entrada <= datos;
      end
      r_visible   <= w_visible_sig;
      r_pendiente <= 1'b0;
    end else if (cargar) begin
      r_entrada   <= datos;
      r_pendiente <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_barrido_display.sv
// ============================================================================
// tb_barrido_display : directed self-checking bench, N_DIGITOS=4, DIV_REFRESCO=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_barrido_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] datos = '0;
  logic        cargar = 1'b0;
  logic        blank_ceros = 1'b0;
  logic        error = 1'b0;
  logic [4:0]  hex;
  logic [3:0]  anodos;
  logic        pendiente;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  barrido_display #(
    .N_DIGITOS    (4),
    .DIV_REFRESCO (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .datos       (datos),
    .cargar      (cargar),
    .blank_ceros (blank_ceros),
    .error       (error),
    .hex         (hex),
    .anodos      (anodos),
    .pendiente   (pendiente)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Slot opens with anodes off, then the slot's digit is driven low.
  function automatic logic [3:0] anod_exp(input int c);
    logic [3:0] uno;
    uno = 4'b0001;
    if (c % 4 == 0) return 4'hF;
    return ~(uno << ((c / 4) % 4));
  endfunction

  // Starts at a frame start (cyc % 16 == 0) and checks all 16 cycles of it.
  task automatic frame_check(input string tag, input logic [4:0] e0, input logic [4:0] e1,
                             input logic [4:0] e2, input logic [4:0] e3);
    logic [4:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      chk(tag, {11'd0, hex}, {11'd0, e[k/4]});
      chk({tag, "_an"}, {12'd0, anodos}, {12'd0, anod_exp(cyc)});
    end
  endtask

  task automatic load_mid(input logic [15:0] v);
    repeat (5) step();
    datos  = v;
    cargar = 1'b1;
    step();
    cargar = 1'b0;
    chk("pend_set", {15'd0, pendiente}, 16'd1);
    repeat (10) step();
    chk("pend_clr", {15'd0, pendiente}, 16'd0);
  endtask

  initial begin
    // asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_an",  {12'd0, anodos},    16'hF);
    chk("async_rst_hex", {11'd0, hex},       16'h10);
    chk("async_rst_pnd", {15'd0, pendiente}, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    chk("rst_an",  {12'd0, anodos},    16'hF);
    chk("rst_hex", {11'd0, hex},       16'h10);
    chk("rst_pnd", {15'd0, pendiente}, 16'd0);

    // free run: zero on every digit, anodes scan with blank first cycle
    for (int c = 1; c <= 32; c++) begin
      step();
      chk("run_an",  {12'd0, anodos}, {12'd0, anod_exp(cyc)});
      chk("run_hex", {11'd0, hex},    16'h00);
    end

    // mid-frame load: old value held until the frame boundary
    repeat (5) step();
    datos  = 16'h12AF;
    cargar = 1'b1;
    step();
    cargar = 1'b0;
    while (cyc < 48) begin
      chk("old_pnd", {15'd0, pendiente}, 16'd1);
      chk("old_hex", {11'd0, hex},       16'h00);
      step();
    end
    chk("new_pnd", {15'd0, pendiente}, 16'd0);
    frame_check("d12AF", 5'h0F, 5'h0A, 5'h02, 5'h01);
    step();

    // leading-zero blanking
    blank_ceros = 1'b1;
    load_mid(16'h0040);
    frame_check("d0040", 5'h00, 5'h04, 5'h10, 5'h10);
    step();
    load_mid(16'h0000);
    frame_check("d0000", 5'h00, 5'h10, 5'h10, 5'h10);
    step();

    // error raised in digit 2's slot
    repeat (9) step();
    chk("pre_err", {11'd0, hex}, 16'h10);
    error = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      chk("err_hex", {11'd0, hex}, 16'h11);
      step();
    end
    chk("err_hex", {11'd0, hex}, 16'h11);
    error = 1'b0;
    step();
    chk("err_off3", {11'd0, hex}, 16'h10);
    while (cyc < 160) step();
    chk("err_off0", {11'd0, hex}, 16'h00);

    // load on the boundary cycle while another load is pending
    repeat (5) step();
    datos  = 16'h1234;
    cargar = 1'b1;
    step();
    cargar = 1'b0;
    chk("bnd_pnd1", {15'd0, pendiente}, 16'd1);
    repeat (9) step();
    datos  = 16'hBEEF;
    cargar = 1'b1;
    step();
    cargar = 1'b0;
    chk("bnd_pnd0", {15'd0, pendiente}, 16'd0);
    frame_check("dBEEF", 5'h0F, 5'h0E, 5'h0E, 5'h0B);

    // asynchronous reset mid-slot discards a pending load
    step();
    datos  = 16'h5555;
    cargar = 1'b1;
    step();
    cargar = 1'b0;
    chk("pre_rst_pnd", {15'd0, pendiente}, 16'd1);
    chk("pre_rst_hex", {11'd0, hex},       16'h0F);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an",  {12'd0, anodos},    16'hF);
    chk("mid_rst_hex", {11'd0, hex},       16'h10);
    chk("mid_rst_pnd", {15'd0, pendiente}, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    step();
    chk("post_rst_an",  {12'd0, anodos}, 16'hE);
    chk("post_rst_hex", {11'd0, hex},    16'h00);
    while (cyc < 16) step();
    chk("discard_hex", {11'd0, hex},       16'h00);
    chk("discard_pnd", {15'd0, pendiente}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
